ncl_sync2dr_tx: RTL and testbench
=================================

// Module: ncl_sync2dr_tx
// PURPOSE
//  Clocked transmitter driving a dual-rail NCL bus with four-phase DATA/NULL wavefronts.
//  Accepts words over a valid/ready interface, encodes each as a DATA wavefront, and returns the bus to NULL.
//  Sequencing follows the receiver's completion signal ki (1 = request-for-data, 0 = request-for-null).
//  Sits at the sync-to-NCL boundary, feeding threshold-gate pipelines (th34w2 etc.) built from the static library.
// PARAMETERS
//  WIDTH        4   data bits; the bus carries WIDTH dual-rail pairs
//  SYNC_STAGES  2   flop stages on the asynchronous ki input; legal range 2..4
//  CNT_W        16  width of the completed-wavefront counter
// PORTS
//  clk         in   1        single clock; all state updates on its rising edge
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        word available on in_data
//  in_ready    out  1        block can accept a word this cycle
//  in_data     in   WIDTH    word to transmit
//  rail1       out  WIDTH    dual-rail true rails; bit i = 1 encodes DATA1
//  rail0       out  WIDTH    dual-rail false rails; bit i = 1 encodes DATA0
//  ki          in   1        receiver completion (async); 1 = rfd, 0 = rfn
//  err_clr     in   1        clears proto_err (synchronous)
//  proto_err   out  1        sticky: ki fell while the bus was NULL
//  tx_count    out  CNT_W    count of DATA wavefronts acknowledged (ki fell in S_DATA)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - rail1=rail0=0 (NULL); state=S_NULL; sync flops=0.
//    - proto_err=0; tx_count=0; in_ready=0 until synchronised ki (ki_s) reads 1.
//  - ki_s is the output of the SYNC_STAGES flop chain.
//    - Nothing combinational sees raw ki.
//    - ki_prev holds ki_s delayed one cycle, for edge detection.
//  - rail1/rail0 come straight from flops; no logic after the registers.
//    - Pair {rail1[i],rail0[i]}=11 never occurs, including across reset.
//  - S_NULL:
//    - Bus NULL; in_ready = ki_s.
//    - On in_valid&&in_ready at edge T: rail1<=in_data, rail0<=~in_data, state<=S_DATA.
//    - DATA is visible after T, i.e. latency 1 cycle.
//    - in_valid with ki_s=0: no accept; rails stay NULL.
//  - S_DATA:
//    - Rails hold the latched word; in_ready=0; in_data and in_valid are ignored.
//    - When ki_s==0: rails<=0 (NULL), state<=S_NULL, tx_count<=tx_count+1.
//    - tx_count wraps modulo 2^CNT_W.
//  - Next accept requires ki_s==1 again, i.e. the receiver has seen NULL.
//    - Stale ki_s=1 is impossible: leaving S_DATA requires ki_s=0.
//  - proto_err:
//    - Set when state==S_NULL && ki_prev==1 && ki_s==0, i.e. rfn without DATA.
//    - err_clr and a set in the same cycle: set wins.
//    - Otherwise err_clr=1 clears it.
//    - proto_err has no effect on sequencing.
//  - Throughput bound:
//    - One word per >= 2*(SYNC_STAGES+1) cycles, plus receiver latency.
//    - No DATA-to-DATA transition without an intervening NULL.
//  - Reset mid-DATA: rails return to NULL asynchronously; the in-flight word is dropped and not counted.
// TESTING
//  - Reset then ki=1 held:
//    - in_ready rises SYNC_STAGES cycles after rst_n deasserts.
//    - Rails 0/0 throughout.
//  - Accept in_data=4'hA at edge T with ki=1:
//    - From T: rail1=4'hA, rail0=4'h5, in_ready=0.
//    - Drop ki=0: rails=0 SYNC_STAGES+1 edges later; tx_count=1.
//  - Back-to-back words 4'h3 then 4'hC, in_valid held high:
//    - Second DATA appears only after ki returns to 1.
//    - Bus NULL between words; no 11 pair at any sample.
//  - ki falls while in S_NULL with no word sent:
//    - proto_err=1 and stays 1.
//    - err_clr pulse -> 0; clear in the same cycle as a new fall -> stays 1.
//  - rst_n pulsed low while in S_DATA holding 4'hF:
//    - Rails immediately 0/0, tx_count=0, state S_NULL.
//  - CNT_W=2, 5 complete cycles -> tx_count=1 (wrap).

Source files
------------

// File: rtl/ncl_sync2dr_tx.sv
// ncl_sync2dr_tx
//   Clocked transmitter that drives a dual-rail NCL bus with four-phase
//   DATA/NULL wavefronts. A word accepted on the valid/ready side is put on
//   the bus as a DATA wavefront. The bus goes back to NULL once the receiver
//   drops its completion signal ki. The receiver must then raise ki again
//   before the next word can be accepted.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a word is present on in_data
//   in_ready   : the block accepts a word this cycle
//   in_data    : word to transmit (WIDTH bits)
//   rail1      : true rails, bit i = 1 encodes DATA1
//   rail0      : false rails, bit i = 1 encodes DATA0
//   ki         : receiver completion, asynchronous (1 = rfd, 0 = rfn)
//   err_clr    : synchronous clear of proto_err
//   proto_err  : sticky flag, set when ki falls while the bus is NULL
//   tx_count   : number of DATA wavefronts acknowledged (wraps)
module ncl_sync2dr_tx #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] rail1,
  output logic [WIDTH-1:0] rail0,
  input  logic             ki,
  input  logic             err_clr,
  output logic             proto_err,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic {
    S_NULL = 1'b0,
    S_DATA = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ki_prev_q, ki_prev_d;
  logic [WIDTH-1:0]       rail1_q, rail1_d;
  logic [WIDTH-1:0]       rail0_q, rail0_d;
  logic                   proto_err_q, proto_err_d;
  logic [CNT_W-1:0]       tx_count_q, tx_count_d;
  logic                   ki_s;

  // Only the last stage of the synchroniser is used anywhere; raw ki feeds
  // the first flop and nothing else.
  assign ki_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], ki};
    ki_prev_d   = ki_s;
    state_d     = state_q;
    rail1_d     = rail1_q;
    rail0_d     = rail0_q;
    tx_count_d  = tx_count_q;
    proto_err_d = proto_err_q;

    case (state_q)
      S_NULL: begin
        if (in_valid && ki_s) begin
          rail1_d = in_data;
          rail0_d = ~in_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!ki_s) begin
          rail1_d    = '0;
          rail0_d    = '0;
          state_d    = S_NULL;
          tx_count_d = tx_count_q + CNT_W'(1);
        end
      end
      default: begin
        rail1_d = '0;
        rail0_d = '0;
        state_d = S_NULL;
      end
    endcase

    // A fall of ki_s with no DATA on the bus is an rfn without data.
    // A set takes priority over a clear in the same cycle.
    if (state_q == S_NULL && ki_prev_q && !ki_s) begin
      proto_err_d = 1'b1;
    end else if (err_clr) begin
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NULL;
      sync_q      <= '0;
      ki_prev_q   <= 1'b0;
      rail1_q     <= '0;
      rail0_q     <= '0;
      proto_err_q <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      ki_prev_q   <= ki_prev_d;
      rail1_q     <= rail1_d;
      rail0_q     <= rail0_d;
      proto_err_q <= proto_err_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign in_ready  = (state_q == S_NULL) && ki_s;
  assign rail1     = rail1_q;
  assign rail0     = rail0_q;
  assign proto_err = proto_err_q;
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_ncl_sync2dr_tx.sv
// Testbench for ncl_sync2dr_tx. Two instances receive the same stimulus:
// the default configuration and one with a 2-bit counter that exercises the
// wrap. A queue-based model of the ki synchroniser and of the word on the
// bus gives the expected outputs after every clock.
module tb_ncl_sync2dr_tx;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = 4'h0;
  logic        ki = 1'b0;
  logic        err_clr = 1'b0;

  logic        in_ready, proto_err;
  logic [3:0]  rail1, rail0;
  logic [15:0] tx_count;
  logic        in_ready_w, proto_err_w;
  logic [3:0]  rail1_w, rail0_w;
  logic [1:0]  tx_count_w;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit          m_hist[$];   // ki samples, newest at the front
  bit          m_kprev;
  bit          m_busy;      // a word is on the bus
  logic [3:0]  m_word;
  bit          m_err;
  int unsigned m_cnt;

  ncl_sync2dr_tx #(.WIDTH(4), .SYNC_STAGES(SS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rail1(rail1), .rail0(rail0), .ki(ki),
    .err_clr(err_clr), .proto_err(proto_err), .tx_count(tx_count)
  );

  ncl_sync2dr_tx #(.WIDTH(4), .SYNC_STAGES(SS), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .rail1(rail1_w), .rail0(rail0_w), .ki(ki),
    .err_clr(err_clr), .proto_err(proto_err_w), .tx_count(tx_count_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hist = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(1'b0);
    m_kprev = 1'b0;
    m_busy  = 1'b0;
    m_word  = 4'h0;
    m_err   = 1'b0;
    m_cnt   = 0;
  endfunction

  // One clock edge of the protocol, using the inputs held before the edge.
  function automatic void model_step();
    bit ks;
    ks = m_hist[SS-1];
    if (!m_busy && m_kprev && !ks) m_err = 1'b1;
    else if (err_clr)              m_err = 1'b0;
    if (!m_busy) begin
      if (in_valid && ks) begin
        m_busy = 1'b1;
        m_word = in_data;
      end
    end else if (!ks) begin
      m_busy = 1'b0;
      m_cnt++;
    end
    m_kprev = ks;
    m_hist.push_front(ki);
    void'(m_hist.pop_back());
  endfunction

  task automatic compare_all();
    logic [3:0] e1, e0;
    logic       er;
    e1 = m_busy ? m_word : 4'h0;
    e0 = m_busy ? ~m_word : 4'h0;
    er = !m_busy && m_hist[SS-1];
    check("rail1", 32'(rail1), 32'(e1));
    check("rail0", 32'(rail0), 32'(e0));
    check("in_ready", 32'(in_ready), 32'(er));
    check("proto_err", 32'(proto_err), 32'(m_err));
    check("tx_count", 32'(tx_count), m_cnt % 65536);
    check("no11", 32'(rail1 & rail0), 32'h0);
    check("rail1_w", 32'(rail1_w), 32'(e1));
    check("rail0_w", 32'(rail0_w), 32'(e0));
    check("tx_count_w", 32'(tx_count_w), m_cnt % 4);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    logic [3:0] d;
    rst_n = 1'b0;
    model_reset();
    ki = 1'b1;
    tick(2);
    rst_n = 1'b1;

    // in_ready rises SYNC_STAGES edges after reset release
    tick(1);
    check("lit_ready_early", 32'(in_ready), 32'h0);
    tick(1);
    check("lit_ready_up", 32'(in_ready), 32'h1);
    check("lit_null_rails", 32'({rail1, rail0}), 32'h0);

    // single word 4'hA
    in_valid = 1'b1; in_data = 4'hA;
    tick(1);
    check("lit_A_rail1", 32'(rail1), 32'hA);
    check("lit_A_rail0", 32'(rail0), 32'h5);
    check("lit_A_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    ki = 1'b0;
    tick(2);
    check("lit_A_hold", 32'(rail1), 32'hA);
    tick(1);
    check("lit_A_null", 32'({rail1, rail0}), 32'h0);
    check("lit_A_count", 32'(tx_count), 32'h1);

    // back-to-back words, in_valid held high
    in_valid = 1'b1; in_data = 4'h3; ki = 1'b1;
    tick(3);
    check("lit_3_rail1", 32'(rail1), 32'h3);
    in_data = 4'hC; ki = 1'b0;
    tick(3);
    check("lit_3_null", 32'({rail1, rail0}), 32'h0);
    tick(2);
    check("lit_gap_null", 32'({rail1, rail0}), 32'h0);
    ki = 1'b1;
    tick(2);
    check("lit_C_wait", 32'(rail1), 32'h0);
    tick(1);
    check("lit_C_rail1", 32'(rail1), 32'hC);
    check("lit_C_rail0", 32'(rail0), 32'h3);
    in_valid = 1'b0; ki = 1'b0;
    tick(3);
    check("lit_C_count", 32'(tx_count), 32'h3);

    // ki falls with the bus NULL
    ki = 1'b1;
    tick(3);
    ki = 1'b0;
    tick(2);
    check("lit_err_pre", 32'(proto_err), 32'h0);
    tick(1);
    check("lit_err_set", 32'(proto_err), 32'h1);
    tick(4);
    check("lit_err_sticky", 32'(proto_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    check("lit_err_clr", 32'(proto_err), 32'h0);
    err_clr = 1'b0;
    ki = 1'b1;
    tick(3);
    ki = 1'b0;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    check("lit_err_set_wins", 32'(proto_err), 32'h1);
    err_clr = 1'b0;
    tick(1);
    check("lit_err_after", 32'(proto_err), 32'h1);

    // reset while DATA 4'hF is on the bus
    ki = 1'b1;
    tick(2);
    in_valid = 1'b1; in_data = 4'hF;
    tick(1);
    check("lit_F_rail1", 32'(rail1), 32'hF);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("lit_rst_rails", 32'({rail1, rail0}), 32'h0);
    check("lit_rst_count", 32'(tx_count), 32'h0);
    check("lit_rst_err", 32'(proto_err), 32'h0);
    tick(1);
    rst_n = 1'b1;

    // five complete cycles: 2-bit counter wraps to 1
    for (int k = 0; k < 5; k++) begin
      d = 4'($urandom);
      ki = 1'b1; in_valid = 1'b1; in_data = d;
      tick(3);
      check("lit_wrap_data", 32'(rail1), 32'(d));
      ki = 1'b0; in_valid = 1'b0;
      tick(3);
    end
    check("lit_count5", 32'(tx_count), 32'h5);
    check("lit_count_wrap", 32'(tx_count_w), 32'h1);

    // randomized traffic: mostly a well-behaved receiver, sometimes glitchy
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      err_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0)
        ki = ~ki;
      else if ($urandom_range(0, 2) == 0)
        ki = ((rail1 | rail0) != 4'h0) ? 1'b0 : 1'b1;
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
